// File: rtl/mult32_seq.sv
// Sequential 32x32 unsigned shift-add multiplier driving a fixed-width ripple adder.
// One partial-product step per clock; the 64-bit product is registered on completion.

module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        carry
);
    logic c;

    always_comb begin
        c   = 1'b0;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry = c;
    end
endmodule

// state | meaning
// IDLE  | waiting for Start
// RUN   | one shift-add step per clock, 32 steps
// DONE  | Product valid, Done pulse; Start here begins the next operation
module mult32_seq #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;

    assign add_b = lo_q[0] ? m_q : '0;

    adder32 u_adder (
        .a     (hi_q),
        .b     (add_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    m_d     = A;
                    hi_d    = '0;
                    lo_d    = B;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                {hi_d, lo_d} = {add_carry, add_sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    // Product is only written here, so it never shows partial sums.
                    product_d = {add_carry, add_sum, lo_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);
    assign Product = product_q;
endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: vector table of single multiplies plus
// hand-written sequences for Start-while-busy, mid-run reset and back-to-back.

module tb_mult32_seq;
    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int checks;
    int errors;

    mult32_seq #(.WIDTH(32)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps until Done is seen or the limit expires; returns the number of edges taken.
    task automatic wait_done(input int limit, output int k, output int busy_cnt);
        k = 0;
        busy_cnt = 0;
        while (!Done && k < limit) begin
            if (Busy) busy_cnt++;
            step();
            k++;
        end
    endtask

    initial begin
        int k;
        int busy_cnt;
        int extra_done;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0,         32'hDEAD_BEEF, 64'h0};
        vecs[3] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vecs[4] = '{32'd1,         32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[5] = '{32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};

        // Reset, with Start asserted to show reset wins.
        Rst_n = 1'b0;
        Start = 1'b1;
        A     = 32'd3;
        B     = 32'd5;
        step();
        step();
        Start = 1'b0;
        Rst_n = 1'b1;
        check("reset_busy",    {63'd0, Busy}, 64'd0);
        check("reset_done",    {63'd0, Done}, 64'd0);
        check("reset_product", Product,       64'd0);
        for (int i = 0; i < 5; i++) step();
        check("idle_busy",    {63'd0, Busy}, 64'd0);
        check("idle_done",    {63'd0, Done}, 64'd0);
        check("idle_product", Product,       64'd0);

        foreach (vecs[i]) begin
            A     = vecs[i].a;
            B     = vecs[i].b;
            Start = 1'b1;
            step();
            Start = 1'b0;
            A     = 32'h5A5A_5A5A;
            B     = 32'hA5A5_A5A5;
            wait_done(40, k, busy_cnt);
            check($sformatf("vec%0d_latency", i), 64'(k), 64'd32);
            check($sformatf("vec%0d_busy_cycles", i), 64'(busy_cnt), 64'd32);
            check($sformatf("vec%0d_product", i), Product, vecs[i].p);
            step();
            check($sformatf("vec%0d_done_pulse", i), {63'd0, Done}, 64'd0);
            check($sformatf("vec%0d_hold", i), Product, vecs[i].p);
        end

        // Start pulsed mid-run is ignored.
        A     = 32'd7;
        B     = 32'd6;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        A     = 32'd9;
        B     = 32'd9;
        Start = 1'b1;
        step();
        Start = 1'b0;
        wait_done(40, k, busy_cnt);
        check("ignored_start_latency", 64'(k + 11), 64'd32);
        check("ignored_start_product", Product, 64'd42);
        extra_done = 0;
        step();
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) extra_done++;
            step();
        end
        check("ignored_start_no_second", 64'(extra_done), 64'd0);
        check("ignored_start_hold", Product, 64'd42);

        // Reset in the middle of a run.
        A     = 32'd100;
        B     = 32'd100;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("midrun_busy_before", {63'd0, Busy}, 64'd1);
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        check("midrun_reset_busy",    {63'd0, Busy}, 64'd0);
        check("midrun_reset_done",    {63'd0, Done}, 64'd0);
        check("midrun_reset_product", Product,       64'd0);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) extra_done++;
            step();
        end
        check("midrun_no_done", 64'(extra_done), 64'd0);

        // Back-to-back with Start held high.
        A     = 32'd2;
        B     = 32'd3;
        Start = 1'b1;
        step();
        A     = 32'd4;
        B     = 32'd5;
        wait_done(40, k, busy_cnt);
        check("b2b_first_latency", 64'(k), 64'd32);
        check("b2b_first_product", Product, 64'd6);
        step();
        check("b2b_restart_busy", {63'd0, Busy}, 64'd1);
        for (int i = 0; i < 10; i++) step();
        check("b2b_hold_during_run", Product, 64'd6);
        wait_done(40, k, busy_cnt);
        check("b2b_second_interval", 64'(k + 11), 64'd33);
        check("b2b_second_product", Product, 64'd20);
        Start = 1'b0;
        step();
        check("b2b_end_done", {63'd0, Done}, 64'd0);
        check("b2b_end_busy", {63'd0, Busy}, 64'd0);
        check("b2b_end_product", Product, 64'd20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
